// File: rtl/pipe_arith_pkg.sv
// Shared definitions for the pipe_arith datapath.
//   PIPE_LAT : number of register stages between acceptance and result
//   MAX_W    : storage width of the stage payload fields; operands of width
//              W (W <= MAX_W/2) are kept sign/zero-extended to MAX_W
//   s1_t     : stage-1 payload (x1 = a+b, x2 = c-d, d1 = d)
//   s2_t     : stage-2 payload (x3 = x1+x2, d2 = d1)
package pipe_arith_pkg;

  localparam int unsigned PIPE_LAT = 3;
  localparam int unsigned MAX_W    = 32;

  typedef struct packed {
    logic [MAX_W-1:0] x1;
    logic [MAX_W-1:0] x2;
    logic [MAX_W-1:0] d1;
  } s1_t;

  typedef struct packed {
    logic [MAX_W-1:0] x3;
    logic [MAX_W-1:0] d2;
  } s2_t;

  // Reduce v modulo 2^w, then sign- or zero-extend back to MAX_W.
  function automatic logic [MAX_W-1:0] wrap_ext(input logic [MAX_W-1:0] v,
                                                input int unsigned      w,
                                                input bit               sgn);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) r[i] = v[i];
      else       r[i] = sgn & v[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_arith_slice.sv
// Generic valid/ready register slice: one pipeline stage.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : upstream handshake; in_ready = empty or draining
//   in_data               : payload captured on a valid advance
//   out_valid / out_ready : downstream handshake
//   out_data              : registered payload
module pipe_arith_slice #(
  parameter type payload_t = logic
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_valid,
  output logic     in_ready,
  input  payload_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output payload_t out_data
);

  logic     valid_q;
  payload_t data_q;

  // Never depends on in_valid, so chained slices form no combinational loop.
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (in_ready)             valid_q <= in_valid;
      if (in_valid && in_ready) data_q  <= in_data;
    end
  end

endmodule

// File: rtl/pipe_arith.sv
// Three-stage pipelined f = ((a+b) + (c-d)) * d with valid/ready flow control.
//   W, SIGNED             : operand width (2..MAX_W/2), 1 = two's complement
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (a, b, c, d)
//   out_valid / out_ready : result handshake (f, 2W bits)
module pipe_arith
  import pipe_arith_pkg::*;
#(
  parameter int unsigned W      = 10,
  parameter bit          SIGNED = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   c,
  input  logic [W-1:0]   d,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] f
);

  logic [MAX_W-1:0] a_e, b_e, c_e, d_e;
  s1_t              s1_in, s1_out;
  s2_t              s2_in, s2_out;
  logic [2*W-1:0]   s3_in;
  logic             s1_valid, s1_ready;
  logic             s2_valid, s2_ready;

  always_comb begin
    a_e = wrap_ext(MAX_W'(a), W, SIGNED);
    b_e = wrap_ext(MAX_W'(b), W, SIGNED);
    c_e = wrap_ext(MAX_W'(c), W, SIGNED);
    d_e = wrap_ext(MAX_W'(d), W, SIGNED);

    s1_in.x1 = wrap_ext(a_e + b_e, W, SIGNED);
    s1_in.x2 = wrap_ext(c_e - d_e, W, SIGNED);
    s1_in.d1 = d_e;

    s2_in.x3 = wrap_ext(s1_out.x1 + s1_out.x2, W, SIGNED);
    s2_in.d2 = s1_out.d1;

    // Both factors are already extended per SIGNED, so the low 2W bits of a
    // plain 2W x 2W product are the correct signed or unsigned result.
    s3_in = (2*W)'(s2_out.x3) * (2*W)'(s2_out.d2);
  end

  pipe_arith_slice #(
    .payload_t (s1_t)
  ) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s1_ready),
    .out_data  (s1_out)
  );

  pipe_arith_slice #(
    .payload_t (s2_t)
  ) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s1_ready),
    .in_data   (s2_in),
    .out_valid (s2_valid),
    .out_ready (s2_ready),
    .out_data  (s2_out)
  );

  pipe_arith_slice #(
    .payload_t (logic [2*W-1:0])
  ) u_s3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s2_valid),
    .in_ready  (s2_ready),
    .in_data   (s3_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (f)
  );

endmodule

// File: tb/tb_pipe_arith.sv
module tb_pipe_arith;

  localparam int unsigned W = 10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   a = '0, b = '0, c = '0, d = '0;
  logic           in_valid_u = 1'b0, in_valid_s = 1'b0;
  logic           in_ready_u, in_ready_s;
  logic           out_valid_u, out_valid_s;
  logic           out_ready_u = 1'b1, out_ready_s = 1'b1;
  logic [2*W-1:0] f_u, f_s;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [2*W-1:0] exp_u[$];
  logic [2*W-1:0] exp_s[$];

  always #5 clk = ~clk;

  pipe_arith #(.W(W), .SIGNED(1'b0)) dut_u (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_u),
    .in_ready  (in_ready_u),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid_u),
    .out_ready (out_ready_u),
    .f         (f_u)
  );

  pipe_arith #(.W(W), .SIGNED(1'b1)) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_s),
    .in_ready  (in_ready_s),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid_s),
    .out_ready (out_ready_s),
    .f         (f_s)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else pass_cnt++;
  endfunction

  // Scoreboard monitors: a transfer occurs at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid_u && out_ready_u) begin
      if (exp_u.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_unsigned_unexpected: got f=%0d, expected no result", f_u);
      end else begin
        chk("sb_unsigned", 64'(f_u), 64'(exp_u.pop_front()));
      end
    end
    if (rst_n && out_valid_s && out_ready_s) begin
      if (exp_s.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_signed_unexpected: got f=%0d, expected no result", f_s);
      end else begin
        chk("sb_signed", 64'(f_s), 64'(exp_s.pop_front()));
      end
    end
  end

  // Present one operand set; returns after the accepting edge (+1).
  task automatic send(input bit sgn, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] cv, input logic [W-1:0] dv,
                      input logic [2*W-1:0] expv, input bit push, output int waits);
    a = av; b = bv; c = cv; d = dv;
    if (sgn) in_valid_s = 1'b1;
    else     in_valid_u = 1'b1;
    if (push) begin
      if (sgn) exp_s.push_back(expv);
      else     exp_u.push_back(expv);
    end
    waits = 0;
    forever begin
      @(negedge clk);
      if (sgn ? in_ready_s : in_ready_u) break;
      waits++;
      if (waits > 50) begin
        total_cnt++;
        $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected 1");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid_u = 1'b0;
    in_valid_s = 1'b0;
  endtask

  // Count negedges until out_valid; returns 0 when the bound expires.
  task automatic wait_out(input bit sgn, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sgn ? out_valid_s : out_valid_u) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int w, n;

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid_u), 64'd0);
    chk("rst_f", 64'(f_u), 64'd0);
    chk("rst_in_ready", 64'(in_ready_u), 64'd1);
    chk("rst_out_valid_s", 64'(out_valid_s), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic latency, accepted on first edge after reset release
    send(0, 10'd10, 10'd12, 10'd6, 10'd3, 20'd75, 1, w);
    chk("first_edge_accept", 64'(w), 64'd0);
    wait_out(0, n);
    chk("latency_3", 64'(n), 64'd3);
    chk("latency_f", 64'(f_u), 64'd75);
    repeat (3) @(posedge clk); #1;

    // Streaming, one result per cycle
    send(0, 10'd10, 10'd10, 10'd5, 10'd3, 20'd66, 1, w);
    send(0, 10'd11, 10'd11, 10'd1, 10'd4, 20'd76, 1, w);
    chk("stream_no_bubble", 64'(w), 64'd0);
    send(0, 10'd15, 10'd22, 10'd1, 10'd5, 20'd165, 1, w);
    @(negedge clk);
    chk("stream_v0", 64'(out_valid_u), 64'd1);
    chk("stream_f0", 64'(f_u), 64'd66);
    @(negedge clk);
    chk("stream_v1", 64'(out_valid_u), 64'd1);
    chk("stream_f1", 64'(f_u), 64'd76);
    @(negedge clk);
    chk("stream_v2", 64'(out_valid_u), 64'd1);
    chk("stream_f2", 64'(f_u), 64'd165);
    repeat (4) @(posedge clk); #1;

    // Backpressure: three sets fill the pipe, f held for 5 cycles
    out_ready_u = 1'b0;
    send(0, 10'd1, 10'd2, 10'd3, 10'd1, 20'd5, 1, w);
    send(0, 10'd2, 10'd2, 10'd2, 10'd2, 20'd8, 1, w);
    send(0, 10'd0, 10'd0, 10'd7, 10'd2, 20'd10, 1, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 64'(in_ready_u), 64'd0);
      chk("bp_out_valid_held", 64'(out_valid_u), 64'd1);
      chk("bp_f_held", 64'(f_u), 64'd5);
    end
    @(posedge clk); #1;
    out_ready_u = 1'b1;
    send(0, 10'd3, 10'd3, 10'd3, 10'd3, 20'd18, 1, w);
    repeat (6) @(posedge clk); #1;
    chk("bp_all_drained", 64'(exp_u.size()), 64'd0);

    // Unsigned wrap: x3 = 1023
    send(0, 10'd1023, 10'd1, 10'd0, 10'd1, 20'd1023, 1, w);
    wait_out(0, n);
    chk("wrap_latency", 64'(n), 64'd3);
    chk("wrap_f", 64'(f_u), 64'd1023);
    repeat (3) @(posedge clk); #1;

    // Signed: -5 + 2 + 0 - 4 = -7, * 4 = -28
    send(1, 10'h3FB, 10'd2, 10'd0, 10'd4, 20'hFFFE4, 1, w);
    wait_out(1, n);
    chk("signed_latency", 64'(n), 64'd3);
    chk("signed_f", 64'(f_s), 64'hFFFE4);
    repeat (3) @(posedge clk); #1;

    // Reset mid-flight with two sets in the pipe
    out_ready_u = 1'b0;
    send(0, 10'd5, 10'd5, 10'd5, 10'd5, 20'd50, 0, w);
    send(0, 10'd6, 10'd6, 10'd6, 10'd6, 20'd72, 0, w);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_in_flight", 64'(out_valid_u), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid_u), 64'd0);
    chk("mid_rst_f", 64'(f_u), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready_u), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready_u = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mid_no_stale", 64'(out_valid_u), 64'd0);
    end

    chk("final_queue_u", 64'(exp_u.size()), 64'd0);
    chk("final_queue_s", 64'(exp_s.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
